// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for the bit-serial ALU sequencer:
//                1-bit slice select codes, full op codes and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Slice select, op[1:0]
    typedef logic [1:0] sel_t;
    localparam sel_t SEL_AND  = 2'b00;
    localparam sel_t SEL_OR   = 2'b01;
    localparam sel_t SEL_ADD  = 2'b10;
    localparam sel_t SEL_LESS = 2'b11;

    // Full op codes; op[2] inverts b and forces carry-in for the adder path
    typedef logic [2:0] op_t;
    localparam op_t OP_AND = 3'b000;
    localparam op_t OP_OR  = 3'b001;
    localparam op_t OP_ADD = 3'b010;
    localparam op_t OP_SUB = 3'b110;
    localparam op_t OP_SLT = 3'b111;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bit_slice
//  Description : 1-bit ALU cell: AND / OR / full-add / LESS pass-through.
//                The invert input only affects the adder path, so AND and OR
//                always see the true b bit.
//  Ports       : i_a, i_b     operand bits
//                i_sel        slice select (SEL_*)
//                i_invert     invert b on the adder path
//                i_cin        carry in
//                i_less       value passed out when sel == SEL_LESS
//                o_sum        selected slice output
//                o_cout       adder carry out (valid for every select)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic [1:0] i_sel,
    input  logic       i_invert,
    input  logic       i_cin,
    input  logic       i_less,
    output logic       o_sum,
    output logic       o_cout
);

    logic w_binv;
    logic w_add;

    always_comb begin
        w_binv = i_b ^ i_invert;
        w_add  = i_a ^ w_binv ^ i_cin;
        o_cout = (i_a & w_binv) | (i_a & i_cin) | (w_binv & i_cin);
        o_sum  = 1'b0;
        case (i_sel)
            SEL_AND: o_sum = i_a & i_b;
            SEL_OR:  o_sum = i_a | i_b;
            SEL_ADD: o_sum = w_add;
            default: o_sum = i_less;
        endcase
    end

endmodule : alu_bit_slice
`default_nettype wire

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_seq
//  Description : Bit-serial ALU sequencer. One WIDTH-bit operation is
//                processed LSB first through a single alu_bit_slice with a
//                carry flop between bits. Non-LESS ops complete in WIDTH
//                cycles, LESS ops take one extra FIX cycle.
//  Ports       : clk, rst_n        clock / async active-low reset
//                i_start           request, sampled only in IDLE
//                i_op[2:0]         {invert/cin, sel[1:0]}
//                i_a, i_b          operands, sampled with i_start
//                o_busy            operation in progress
//                o_done            one-cycle completion pulse
//                o_result          published result, held until next done
//                o_cout            carry out of the MSB
//                o_overflow        signed overflow (ADD/SUB only)
//                o_zero            o_result == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic [2:0]         r_op;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_cin_msb;
    logic               r_cout_msb;
    logic               r_sum_msb;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_overflow;

    logic               w_slice_sum;
    logic               w_slice_cout;
    logic               w_add_sum;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    alu_bit_slice u_slice (
        .i_a      (r_a_sr[0]),
        .i_b      (r_b_sr[0]),
        .i_sel    (r_op[1:0]),
        .i_invert (r_op[2]),
        .i_cin    (r_carry),
        .i_less   (1'b0),
        .o_sum    (w_slice_sum),
        .o_cout   (w_slice_cout)
    );

    // The slice returns 0 for LESS, but FIX needs the true adder sum of the
    // MSB to form the sign of a-b, so that one bit is recomputed here.
    assign w_add_sum  = r_a_sr[0] ^ r_b_sr[0] ^ r_op[2] ^ r_carry;
    assign w_last     = (r_cnt == c_LAST);
    // New bit enters at the MSB; after WIDTH shifts bit i sits at position i.
    assign w_res_next = {w_slice_sum, r_res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_res_sr   <= '0;
            r_op       <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_cin_msb  <= 1'b0;
            r_cout_msb <= 1'b0;
            r_sum_msb  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a_sr  <= i_a;
                        r_b_sr  <= i_b;
                        r_op    <= i_op;
                        r_carry <= i_op[2];
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_res_sr <= w_res_next;
                    r_carry  <= w_slice_cout;
                    // Held at the last index rather than wrapping; it is
                    // reloaded on the next accept anyway.
                    if (!w_last) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                    if (w_last) begin
                        r_cin_msb  <= r_carry;
                        r_cout_msb <= w_slice_cout;
                        r_sum_msb  <= w_add_sum;
                        if (r_op[1:0] == SEL_LESS) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_result   <= w_res_next;
                            r_cout     <= w_slice_cout;
                            r_overflow <= (r_op[1:0] == SEL_ADD) &
                                          (r_carry ^ w_slice_cout);
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end

                ST_FIX: begin
                    // Signed less-than: sign of a-b corrected by overflow.
                    r_result   <= {{(WIDTH-1){1'b0}},
                                   r_sum_msb ^ (r_cin_msb ^ r_cout_msb)};
                    r_cout     <= r_cout_msb;
                    r_overflow <= 1'b0;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_result   = r_result;
    assign o_cout     = r_cout;
    assign o_overflow = r_overflow;
    assign o_zero     = (r_result == '0);

endmodule : alu_serial_seq
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial_seq
//  Description : Scoreboard bench for alu_serial_seq (WIDTH = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_seq;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [2:0]   i_op;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_result;
    logic         o_cout;
    logic         o_overflow;
    logic         o_zero;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    exp_t q[$];
    exp_t m_e;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_cout     (o_cout),
        .o_overflow (o_overflow),
        .o_zero     (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Independent reference: full-width arithmetic, no bit serialisation.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op);
        exp_t       e;
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         v;
        bb     = op[2] ? ~b : b;
        s      = {1'b0, a} + {1'b0, bb} + (W+1)'(op[2]);
        v      = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        e.cout = s[W];
        e.ovf  = 1'b0;
        e.lat  = W;
        e.acc  = 0;
        case (op[1:0])
            2'b00:   e.res = a & b;
            2'b01:   e.res = a | b;
            2'b10:   begin e.res = s[W-1:0]; e.ovf = v; end
            default: begin e.res = {{(W-1){1'b0}}, s[W-1] ^ v}; e.lat = W + 1; end
        endcase
        return e;
    endfunction

    // Output monitor: every done pulse must match the oldest expectation.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (prev_done) chk("done_width", 1, 0);
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                m_e = q.pop_front();
                chk("result",   64'(o_result),   64'(m_e.res));
                chk("cout",     64'(o_cout),     64'(m_e.cout));
                chk("overflow", 64'(o_overflow), 64'(m_e.ovf));
                chk("zero",     64'(o_zero),     64'(m_e.res == '0));
                chk("busy_at_done", 64'(o_busy), 0);
                chk("latency",  64'(cyc - m_e.acc), 64'(m_e.lat));
            end
        end
        prev_done = o_done;
    end

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t e;
        @(negedge clk);
        i_a = a; i_b = b; i_op = op; i_start = 1'b1;
        e = model(a, b, op);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("timeout", 64'(q.size()), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        rst_n = 1'b0; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(o_busy), 0);
        chk("rst_done", 64'(o_done), 0);
        chk("rst_result", 64'(o_result), 0);
        chk("rst_zero", 64'(o_zero), 1);
        chk("rst_cout", 64'(o_cout), 0);
        chk("rst_ovf", 64'(o_overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        drive_op(32'd5, 32'd7, OP_ADD);                      wait_idle();
        drive_op(32'd3, 32'd5, OP_SUB);                      wait_idle();
        drive_op(32'd9, 32'd9, OP_SUB);                      wait_idle();
        drive_op(32'hFFFF_FFFF, 32'd1, OP_SLT);              wait_idle();
        drive_op(32'h7FFF_FFFF, 32'h8000_0000, OP_SLT);      wait_idle();
        drive_op(32'h7FFF_FFFF, 32'd1, OP_ADD);              wait_idle();
        drive_op(32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND);      wait_idle();
        drive_op(32'h1234_0000, 32'h0000_5678, 3'b101);      wait_idle();
        drive_op(32'h0000_0003, 32'hFFFF_FFFE, 3'b011);      wait_idle();
        drive_op(32'h8000_0000, 32'h8000_0000, OP_ADD);      wait_idle();
        drive_op(32'd10, 32'd20, OP_SLT);                    wait_idle();

        // start mid-run must be ignored
        drive_op(32'd100, 32'd23, OP_ADD);
        repeat (8) @(negedge clk);
        i_a = 32'hDEAD_BEEF; i_b = 32'h1; i_op = OP_SUB; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_idle();

        // start held through done: second op accepted in the done cycle
        drive_op(32'd40, 32'd2, OP_ADD);
        i_a = 32'd50; i_b = 32'd8; i_op = OP_SUB; i_start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        chk("b2b_first_done", 64'(seen), 1);
        e = model(32'd50, 32'd8, OP_SUB);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
        chk("b2b_busy", 64'(o_busy), 1);
        wait_idle();

        // asynchronous reset mid-run
        drive_op(32'd77, 32'd11, OP_ADD);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(o_busy), 0);
        chk("arst_done", 64'(o_done), 0);
        chk("arst_result", 64'(o_result), 0);
        chk("arst_zero", 64'(o_zero), 1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_op(32'd1, 32'd1, OP_ADD);                      wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_alu_serial_seq
`default_nettype wire
